// File: rtl/aclock_pkg.sv
// Shared definitions for the alarm clock setting controller.
// Holds the controller state encoding, the field limits and the
// binary <-> BCD helpers used for the time/alarm edit registers.
package aclock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T_HR,
    T_MIN,
    T_LOAD,
    A_HR,
    A_MIN,
    A_LOAD
  } state_t;

  localparam logic [5:0] HR_MAX  = 6'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // 6-bit binary (0..63) to {tens, ones} BCD by repeated subtraction.
  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, 4'(rem)};
  endfunction

  // Two BCD digits to binary: tens*10 + ones, built from shifts.
  function automatic logic [5:0] bcd2bin(input logic [3:0] tens,
                                         input logic [3:0] ones);
    logic [5:0] t6;
    t6 = {2'b00, tens};
    return (t6 << 3) + (t6 << 1) + {2'b00, ones};
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: two-flop synchronizer followed by a rising-edge
// detector. The pulse is decoded from registers only, so there is no
// combinational path from the raw button to the pulse.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   btn    raw (debounced) button level
//   rise   one-cycle pulse on a synchronized 0->1 transition
module btn_cond (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~prev_reg;

endmodule

// File: rtl/aclock_set_ctrl.sv
// Setting controller for the alarm clock core. Turns MODE / INC / ALARM
// button edges into time and alarm edit sessions, produces the BCD load
// values and stretched LD_time / LD_alarm / STOP_al strobes, and owns the
// AL_ON enable.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   btn_mode, btn_inc, btn_alm       debounced button levels
//   cur_H1/H0/M1/M0                  current time (BCD) from the core
//   Alarm                            core alarm output
//   H_in1/H_in0/M_in1/M_in0          registered BCD load value to the core
//   LD_time, LD_alarm, STOP_al       stretched strobes (LD_HOLD cycles)
//   AL_ON                            alarm enable
//   edit_hr, edit_min                field-under-edit flags for blinking
module aclock_set_ctrl
  import aclock_pkg::*;
#(
  parameter int LD_HOLD = 12,
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_alm,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  input  logic       Alarm,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic       edit_hr,
  output logic       edit_min
);

  localparam int HW = $clog2(LD_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // Button conditioning: index 0 = mode, 1 = inc, 2 = alm.
  logic [2:0] btn_raw;
  logic [2:0] rise;

  assign btn_raw = {btn_alm, btn_inc, btn_mode};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      btn_cond u_btn_cond (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_raw[gi]),
        .rise  (rise[gi])
      );
    end
  endgenerate

  logic rise_mode;
  logic rise_inc;
  logic rise_alm;
  logic any_rise;

  assign rise_mode = rise[0];
  assign rise_inc  = rise[1];
  assign rise_alm  = rise[2];
  assign any_rise  = |rise;

  state_t        state_reg, state_next;
  logic [5:0]    ed_h_reg, ed_h_next;
  logic [5:0]    ed_m_reg, ed_m_next;
  logic [5:0]    al_h_reg, al_h_next;
  logic [5:0]    al_m_reg, al_m_next;
  logic          al_on_reg, al_on_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  logic [HW-1:0] stop_cnt_reg, stop_cnt_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic          in_edit;

  logic          ld_time_reg, ld_alarm_reg;
  logic          edit_hr_reg, edit_min_reg;
  logic [1:0]    h_in1_reg, h_in1_next;
  logic [3:0]    h_in0_reg, h_in0_next;
  logic [3:0]    m_in1_reg, m_in1_next;
  logic [3:0]    m_in0_reg, m_in0_next;

  assign in_edit = (state_reg == T_HR) || (state_reg == T_MIN) ||
                   (state_reg == A_HR) || (state_reg == A_MIN);

  always_comb begin
    state_next    = state_reg;
    ed_h_next     = ed_h_reg;
    ed_m_next     = ed_m_reg;
    al_h_next     = al_h_reg;
    al_m_next     = al_m_reg;
    al_on_next    = al_on_reg;
    hold_cnt_next = '0;
    tmo_cnt_next  = '0;
    stop_cnt_next = (stop_cnt_reg != '0) ? stop_cnt_reg - HW'(1) : '0;

    case (state_reg)
      IDLE: begin
        if (any_rise) begin
          if (Alarm) begin
            // Any press silences the alarm; (re)start the stop stretch.
            stop_cnt_next = HW'(LD_HOLD);
          end else if (rise_mode) begin
            ed_h_next  = bcd2bin({2'b00, cur_H1}, cur_H0);
            ed_m_next  = bcd2bin(cur_M1, cur_M0);
            state_next = T_HR;
          end else if (rise_alm) begin
            ed_h_next  = al_h_reg;
            ed_m_next  = al_m_reg;
            state_next = A_HR;
          end else begin
            al_on_next = ~al_on_reg;
          end
        end
      end
      T_HR, A_HR: begin
        if (rise_mode) begin
          state_next = (state_reg == T_HR) ? T_MIN : A_MIN;
        end else if (rise_inc) begin
          ed_h_next = (ed_h_reg >= HR_MAX) ? 6'd0 : ed_h_reg + 6'd1;
        end
      end
      T_MIN, A_MIN: begin
        if (rise_mode) begin
          state_next = (state_reg == T_MIN) ? T_LOAD : A_LOAD;
        end else if (rise_inc) begin
          ed_m_next = (ed_m_reg >= MIN_MAX) ? 6'd0 : ed_m_reg + 6'd1;
        end
      end
      T_LOAD, A_LOAD: begin
        if (state_reg == A_LOAD) begin
          al_h_next = ed_h_reg;
          al_m_next = ed_m_reg;
        end
        // Leaving on the LD_HOLD-th edge makes the strobe exactly LD_HOLD
        // cycles wide, falling on the same edge that re-enters IDLE.
        if (hold_cnt_reg == HW'(LD_HOLD - 1)) begin
          state_next = IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg + HW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Inactivity timeout: any edge restarts the count; expiry abandons
    // the session without a strobe (no edge can be pending on expiry).
    if (in_edit) begin
      if (any_rise) begin
        tmo_cnt_next = '0;
      end else if (tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
        state_next = IDLE;
      end else begin
        tmo_cnt_next = tmo_cnt_reg + TW'(1);
      end
    end
  end

  // BCD split is taken from the next-state edit values so the registered
  // outputs always equal the BCD of the current edit registers.
  always_comb begin
    {h_in1_next, h_in0_next} = 6'(bin2bcd(ed_h_next));
    {m_in1_next, m_in0_next} = bin2bcd(ed_m_next);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      ed_h_reg     <= '0;
      ed_m_reg     <= '0;
      al_h_reg     <= '0;
      al_m_reg     <= '0;
      al_on_reg    <= 1'b0;
      hold_cnt_reg <= '0;
      stop_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      ld_time_reg  <= 1'b0;
      ld_alarm_reg <= 1'b0;
      edit_hr_reg  <= 1'b0;
      edit_min_reg <= 1'b0;
      h_in1_reg    <= '0;
      h_in0_reg    <= '0;
      m_in1_reg    <= '0;
      m_in0_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      ed_h_reg     <= ed_h_next;
      ed_m_reg     <= ed_m_next;
      al_h_reg     <= al_h_next;
      al_m_reg     <= al_m_next;
      al_on_reg    <= al_on_next;
      hold_cnt_reg <= hold_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      ld_time_reg  <= (state_next == T_LOAD);
      ld_alarm_reg <= (state_next == A_LOAD);
      edit_hr_reg  <= (state_next == T_HR) || (state_next == A_HR);
      edit_min_reg <= (state_next == T_MIN) || (state_next == A_MIN);
      h_in1_reg    <= h_in1_next;
      h_in0_reg    <= h_in0_next;
      m_in1_reg    <= m_in1_next;
      m_in0_reg    <= m_in0_next;
    end
  end

  assign H_in1    = h_in1_reg;
  assign H_in0    = h_in0_reg;
  assign M_in1    = m_in1_reg;
  assign M_in0    = m_in0_reg;
  assign LD_time  = ld_time_reg;
  assign LD_alarm = ld_alarm_reg;
  assign STOP_al  = (stop_cnt_reg != '0);
  assign AL_ON    = al_on_reg;
  assign edit_hr  = edit_hr_reg;
  assign edit_min = edit_min_reg;

endmodule

// File: tb/tb_aclock_set_ctrl.sv
// Directed testbench for aclock_set_ctrl: time set, wraps, alarm load,
// AL_ON toggle, alarm stop, timeout, simultaneous presses, reset mid-load.
module tb_aclock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_alm = 1'b0;
  logic [1:0] cur_H1 = '0;
  logic [3:0] cur_H0 = '0;
  logic [3:0] cur_M1 = '0;
  logic [3:0] cur_M0 = '0;
  logic       Alarm = 1'b0;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time;
  logic       LD_alarm;
  logic       STOP_al;
  logic       AL_ON;
  logic       edit_hr;
  logic       edit_min;

  aclock_set_ctrl #(.LD_HOLD(12), .TIMEOUT(1000)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .btn_alm  (btn_alm),
    .cur_H1   (cur_H1),
    .cur_H0   (cur_H0),
    .cur_M1   (cur_M1),
    .cur_M0   (cur_M0),
    .Alarm    (Alarm),
    .H_in1    (H_in1),
    .H_in0    (H_in0),
    .M_in1    (M_in1),
    .M_in0    (M_in0),
    .LD_time  (LD_time),
    .LD_alarm (LD_alarm),
    .STOP_al  (STOP_al),
    .AL_ON    (AL_ON),
    .edit_hr  (edit_hr),
    .edit_min (edit_min)
  );

  always #5 clk = ~clk;

  // Load value packed as hex digits: 0xHhMm, e.g. 15:36 -> 0x1536.
  logic [13:0] hm_out;
  assign hm_out = {H_in1, H_in0, M_in1, M_in0};

  int checks = 0;
  int failures = 0;

  // Per-press observation counters.
  int n_ldt, n_lda, n_stop, n_ehr, first_ehr;
  bit unstable;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Raise the buttons in mask {alm,inc,mode} for 3 cycles, observe n cycles.
  task automatic press(input logic [2:0] mask, input int n);
    logic [13:0] ref_hm;
    bit have_ref;
    n_ldt = 0; n_lda = 0; n_stop = 0; n_ehr = 0; first_ehr = 0;
    unstable = 1'b0; have_ref = 1'b0; ref_hm = '0;
    @(negedge clk);
    {btn_alm, btn_inc, btn_mode} = mask;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 3) {btn_alm, btn_inc, btn_mode} = 3'b000;
      if (LD_time) n_ldt++;
      if (LD_alarm) n_lda++;
      if (STOP_al) n_stop++;
      if (edit_hr) begin
        n_ehr++;
        if (first_ehr == 0) first_ehr = k;
      end
      if (LD_time || LD_alarm) begin
        if (!have_ref) begin
          ref_hm = hm_out;
          have_ref = 1'b1;
        end else if (hm_out != ref_hm) begin
          unstable = 1'b1;
        end
      end
    end
  endtask

  localparam logic [2:0] P_MODE = 3'b001;
  localparam logic [2:0] P_INC  = 3'b010;
  localparam logic [2:0] P_ALM  = 3'b100;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_hm", 32'(hm_out), 32'h0000);
    chk("rst_strobes", {LD_time, LD_alarm, STOP_al, AL_ON}, 4'b0000);
    chk("rst_edit", {edit_hr, edit_min}, 2'b00);
    reset = 1'b1;
    @(negedge clk);

    // Set time from 12:34 to 15:36
    cur_H1 = 2'd1; cur_H0 = 4'd2; cur_M1 = 4'd3; cur_M0 = 4'd4;
    press(P_MODE, 8);
    chk("t_first_ehr", first_ehr, 3);
    chk("t_edit_hr", edit_hr, 1'b1);
    chk("t_load_cur", 32'(hm_out), 32'h1234);
    for (int i = 0; i < 3; i++) press(P_INC, 8);
    chk("t_hr_inc3", 32'(hm_out), 32'h1534);
    press(P_MODE, 8);
    chk("t_edit_min", {edit_hr, edit_min}, 2'b01);
    for (int i = 0; i < 2; i++) press(P_INC, 8);
    chk("t_min_inc2", 32'(hm_out), 32'h1536);
    press(P_MODE, 30);
    chk("t_ld_time_len", n_ldt, 12);
    chk("t_ld_alarm_none", n_lda, 0);
    chk("t_stable", unstable, 1'b0);
    chk("t_hm_after", 32'(hm_out), 32'h1536);
    chk("t_idle_after", {edit_hr, edit_min, LD_time}, 3'b000);

    // Alarm session with hour and minute wraps
    press(P_ALM, 8);
    chk("a_edit_hr", edit_hr, 1'b1);
    chk("a_load_al", 32'(hm_out), 32'h0000);
    for (int i = 0; i < 22; i++) press(P_INC, 8);
    chk("a_hr22", 32'(hm_out), 32'h2200);
    for (int i = 0; i < 3; i++) press(P_INC, 8);
    chk("a_hr_wrap", 32'(hm_out), 32'h0100);
    press(P_MODE, 8);
    chk("a_edit_min", {edit_hr, edit_min}, 2'b01);
    for (int i = 0; i < 58; i++) press(P_INC, 8);
    chk("a_min58", 32'(hm_out), 32'h0158);
    for (int i = 0; i < 2; i++) press(P_INC, 8);
    chk("a_min_wrap", 32'(hm_out), 32'h0100);
    press(P_MODE, 30);
    chk("a_ld_alarm_len", n_lda, 12);
    chk("a_ld_time_none", n_ldt, 0);
    chk("a_idle_after", {edit_hr, edit_min}, 2'b00);

    // AL_ON toggle, then alarm stop leaves AL_ON and FSM alone
    press(P_INC, 8);
    chk("alon_toggle", AL_ON, 1'b1);
    Alarm = 1'b1;
    press(P_INC, 30);
    chk("stop_len", n_stop, 12);
    chk("stop_alon", AL_ON, 1'b1);
    chk("stop_no_edit", n_ehr, 0);
    chk("stop_no_ld", n_ldt + n_lda, 0);
    chk("stop_hm_kept", 32'(hm_out), 32'h0100);
    Alarm = 1'b0;

    // Timeout from T_HR, then alarm session resumes from stored 01:00
    press(P_MODE, 1020);
    chk("tmo_ehr_len", n_ehr, 1000);
    chk("tmo_no_ld", n_ldt, 0);
    chk("tmo_idle", edit_hr, 1'b0);
    press(P_ALM, 8);
    chk("tmo_al_kept", 32'(hm_out), 32'h0100);
    chk("tmo_al_edit", edit_hr, 1'b1);

    // Simultaneous presses
    do_reset();
    press(P_MODE, 8);
    press(P_MODE | P_INC, 8);
    chk("sim_mode_inc_st", {edit_hr, edit_min}, 2'b01);
    chk("sim_mode_inc_hm", 32'(hm_out), 32'h1234);
    do_reset();
    press(P_MODE | P_ALM, 8);
    chk("sim_mode_alm_st", {edit_hr, edit_min}, 2'b10);
    chk("sim_mode_alm_hm", 32'(hm_out), 32'h1234);

    // Reset during the 5th LD_time cycle
    do_reset();
    press(P_MODE, 8);
    press(P_MODE, 8);
    @(negedge clk);
    btn_mode = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 3) btn_mode = 1'b0;
    end
    chk("mid_ld_high", LD_time, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mid_ld_drop", LD_time, 1'b0);
    chk("mid_hm_zero", 32'(hm_out), 32'h0000);
    chk("mid_flags_zero", {LD_alarm, STOP_al, AL_ON, edit_hr, edit_min}, 5'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
